oc_unary_expander: RTL and testbench
====================================

Name: oc_unary_expander

Overview:
- Inverse of the team's 15-input ones counter: accepts a 4-bit count N and serially builds a 15-bit thermometer word containing exactly N ones, one bit per clock.
- Also emits each generated one on a serial output.
- Sits upstream of the ones counter as a stimulus and loopback source; feeding y back into the counter reproduces N.

Parameters:
- W, 15, output word width (number of counter inputs).
- CW, 4, count width, equal to $clog2(W+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to expand count; accepted only when ready=1.
- count  input  CW  requested number of ones N, sampled on acceptance.
- ready  output  1  high in IDLE only.
- busy  output  1  high in FILL and DONE.
- y  output  W  thermometer word; ones fill from bit 0 upward.
- serial_out  output  1  high in each FILL cycle, when one bit is being added.
- done  output  1  one-cycle pulse when y is final.
- err  output  1  loopback mismatch flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, y=0, remaining=0, n_lat=0, done=0, serial_out=0, err=0, ready=1, busy=0. Reset asserted mid-FILL aborts immediately; no done pulse.
- IDLE:
  - ready=1.
  - On clk edge with start=1: n_lat <= min(count, W), remaining <= min(count, W), y <= 0, err <= 0.
  - Next state is DONE if the clamped count is 0, else FILL.
- FILL:
  - Each cycle: y <= {y[W-2:0], 1'b1}, remaining <= remaining-1, serial_out=1 (combinational from state).
  - When remaining==1 at the edge, next state is DONE.
- DONE:
  - done=1 for exactly this one cycle; next state is IDLE.
- Latency: accept at edge 0 -> N FILL cycles -> done high in cycle N+1. For N=0, done is high in cycle 1.
- y holds its final value through IDLE until the next accepted start clears it.
- start while busy is ignored (not queued). Simultaneous start in the DONE cycle is ignored; a new request is accepted only in IDLE.
- count > W (only possible if W < 2^CW-1) is clamped to W, so y never overflows.
- Invariant: popcount(y) equals the number of FILL cycles elapsed since accept.
- Outputs y, done and err are registered. ready, busy and serial_out are decoded from state.

Optional Feature:
- Macro: OC_UNARY_LOOPBACK_CHECK_EN.
- Defined:
  - A popcount sub-module counts the ones in y.
  - At the DONE-state edge, if the popcount differs from n_lat, err <= 1.
  - err stays sticky until the next accepted start or reset.
- Undefined: no checker logic; err is tied to 0.

Decomposition:
- Package oc_pkg:
  - localparams OC_W=15 and OC_CW=4.
  - typedef enum logic [1:0] {IDLE, FILL, DONE} oc_state_t.
  - typedef logic [OC_CW-1:0] oc_count_t.
- Sub-module oc_popcount (W-in, CW-out, combinational adder tree): instantiated only under OC_UNARY_LOOPBACK_CHECK_EN.
- FSM, counter and shift register live in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-FILL at N=9 after 4 cycles -> y=0, ready=1, busy=0, done never pulses; after release, start with N=3 -> y=15'h0007, done in cycle 4.
- Full expansion: start with count=15 -> serial_out high for 15 cycles; y steps 0001, 0003, ... 7FFF; done high in cycle 16, then ready=1.
- Zero count: start with count=0 -> no serial_out; done in cycle 1; y=0.
- Back-to-back and ignored start:
  - Start N=5, hold start=1 with count=12 during FILL/DONE -> second request ignored until IDLE.
  - Then N=12 expands from y=0 to 15'h0FFF.
- Loopback: drive y into the ones counter for every N in 0..15 -> counter output equals N.
- With OC_UNARY_LOOPBACK_CHECK_EN: force a y bit via the bench -> err=1 after DONE, cleared by the next start.

Source files
------------

// File: rtl/oc_pkg.sv
// Shared types and sizes for the ones-counter family (counter, expander, checkers).
package oc_pkg;

    localparam int OC_W  = 15;
    localparam int OC_CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } oc_state_t;

    typedef logic [OC_CW-1:0] oc_count_t;

endpackage : oc_pkg

// File: rtl/oc_popcount.sv
// Combinational population count of a W-bit word; used by the expander's loopback checker.
module oc_popcount #(
    parameter int W  = 15,
    parameter int CW = 4
) (
    input  logic [W-1:0]  bits_i,
    output logic [CW-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + {{(CW-1){1'b0}}, bits_i[i]};
        end
    end

endmodule : oc_popcount

// File: rtl/oc_unary_expander.sv
// Serial unary expander: turns a count N into a thermometer word with N ones, one bit per clock.
// Optional loopback self-check enabled by defining OC_UNARY_LOOPBACK_CHECK_EN.
module oc_unary_expander
    import oc_pkg::*;
#(
    parameter int W  = OC_W,
    parameter int CW = OC_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] count,
    output logic          ready,
    output logic          busy,
    output logic [W-1:0]  y,
    output logic          serial_out,
    output logic          done,
    output logic          err
);

    localparam logic [CW-1:0] WMAX = CW'(W);

    oc_state_t     state_q, state_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [W-1:0]  y_q, y_d;
    logic          done_q, done_d;
    logic [CW-1:0] clamped;

    assign clamped    = (count > WMAX) ? WMAX : count;
    assign ready      = (state_q == IDLE);
    assign busy       = (state_q == FILL) || (state_q == DONE);
    assign serial_out = (state_q == FILL);
    assign y          = y_q;
    assign done       = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            y_q         <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            y_q         <= y_d;
            done_q      <= done_d;
        end
    end

    // done is registered, so it is raised on the edge that enters DONE
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        y_d         = y_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = clamped;
                    y_d         = '0;
                    state_d     = (clamped == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                y_d         = {y_q[W-2:0], 1'b1};
                remaining_d = remaining_q - 1'b1;
                if (remaining_q == {{(CW-1){1'b0}}, 1'b1}) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d = (state_d == DONE);
    end

`ifdef OC_UNARY_LOOPBACK_CHECK_EN
    logic [CW-1:0] n_lat_q, n_lat_d;
    logic [CW-1:0] y_ones;
    logic          err_q, err_d;

    oc_popcount #(
        .W  (W),
        .CW (CW)
    ) u_popcount (
        .bits_i  (y_q),
        .count_o (y_ones)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_lat_q <= '0;
            err_q   <= 1'b0;
        end else begin
            n_lat_q <= n_lat_d;
            err_q   <= err_d;
        end
    end

    // err is sticky: only a newly accepted request clears it
    always_comb begin
        n_lat_d = n_lat_q;
        err_d   = err_q;
        if ((state_q == IDLE) && start) begin
            n_lat_d = clamped;
            err_d   = 1'b0;
        end else if ((state_q == DONE) && (y_ones != n_lat_q)) begin
            err_d = 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule : oc_unary_expander

// File: tb/tb_oc_unary_expander.sv
// Directed bench for oc_unary_expander: table of counts 0..15 plus reset, hold-start and loopback sequences.
module tb_oc_unary_expander;

    typedef struct {
        logic [3:0]  cnt;
        logic [14:0] expY;
        int          expDoneCycle;
        int          expSerial;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  count;
    logic        ready;
    logic        busy;
    logic [14:0] y;
    logic        serial_out;
    logic        done;
    logic        err;

    int testsRun = 0;
    int testsFailed = 0;

    oc_unary_expander dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .count      (count),
        .ready      (ready),
        .busy       (busy),
        .y          (y),
        .serial_out (serial_out),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent loopback model of the ones counter
    function automatic int onesCount(input logic [14:0] v);
        int n = 0;
        for (int i = 0; i < 15; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives a request on the falling edge and returns just after the accepting edge
    task automatic applyStimulus(input logic [3:0] n);
        @(negedge clk);
        start = 1'b1;
        count = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Watches cycles 1.. after acceptance until done, checking the thermometer progression
    task automatic waitForDone(input string tag, input logic [14:0] expY, input int expDoneCycle,
                               input int expSerial);
        int cyc = 0;
        int serialSeen = 0;
        logic stepOk = 1'b1;
        logic busyOk = 1'b1;
        logic [14:0] stepExp;
        logic seenDone = 1'b0;
        while (!seenDone && cyc < 40) begin
            @(negedge clk);
            cyc++;
            stepExp = (cyc <= expSerial + 1) ? 15'((32'd1 << (cyc - 1)) - 1) : expY;
            if (y !== stepExp) stepOk = 1'b0;
            if (busy !== 1'b1 || ready !== 1'b0) busyOk = 1'b0;
            if (serial_out === 1'b1) serialSeen++;
            if (done === 1'b1) seenDone = 1'b1;
        end
        checkOutput({tag, " done_cycle"}, seenDone ? cyc : -1, expDoneCycle);
        checkOutput({tag, " serial_count"}, serialSeen, expSerial);
        checkOutput({tag, " y_steps_ok"}, {31'd0, stepOk}, 1);
        checkOutput({tag, " busy_ok"}, {31'd0, busyOk}, 1);
        checkOutput({tag, " y_final"}, {17'd0, y}, {17'd0, expY});
        checkOutput({tag, " loopback"}, onesCount(y), expSerial);
        @(negedge clk);
        checkOutput({tag, " ready_after"}, {29'd0, ready, busy, done}, 32'b100);
        checkOutput({tag, " y_held"}, {17'd0, y}, {17'd0, expY});
        checkOutput({tag, " err"}, {31'd0, err}, 0);
    endtask

    initial begin
        vec_t vecs[16];
        logic doneLeak;

        vecs[0]  = '{4'd0,  15'h0000, 1,  0};
        vecs[1]  = '{4'd1,  15'h0001, 2,  1};
        vecs[2]  = '{4'd2,  15'h0003, 3,  2};
        vecs[3]  = '{4'd3,  15'h0007, 4,  3};
        vecs[4]  = '{4'd4,  15'h000F, 5,  4};
        vecs[5]  = '{4'd5,  15'h001F, 6,  5};
        vecs[6]  = '{4'd6,  15'h003F, 7,  6};
        vecs[7]  = '{4'd7,  15'h007F, 8,  7};
        vecs[8]  = '{4'd8,  15'h00FF, 9,  8};
        vecs[9]  = '{4'd9,  15'h01FF, 10, 9};
        vecs[10] = '{4'd10, 15'h03FF, 11, 10};
        vecs[11] = '{4'd11, 15'h07FF, 12, 11};
        vecs[12] = '{4'd12, 15'h0FFF, 13, 12};
        vecs[13] = '{4'd13, 15'h1FFF, 14, 13};
        vecs[14] = '{4'd14, 15'h3FFF, 15, 14};
        vecs[15] = '{4'd15, 15'h7FFF, 16, 15};

        rst_n = 1'b0;
        start = 1'b0;
        count = 4'd0;
        #12;
        checkOutput("reset y", {17'd0, y}, 0);
        checkOutput("reset ready/busy/serial/done/err", {27'd0, ready, busy, serial_out, done, err},
                    32'b10000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].cnt);
            waitForDone($sformatf("vec%0d", i), vecs[i].expY, vecs[i].expDoneCycle, vecs[i].expSerial);
        end

        // Reset in the middle of a fill aborts without a done pulse
        applyStimulus(4'd9);
        repeat (4) @(negedge clk);
        checkOutput("midfill y", {17'd0, y}, 32'h0007);
        rst_n = 1'b0;
        #1;
        checkOutput("abort y", {17'd0, y}, 0);
        checkOutput("abort ready/busy/done", {29'd0, ready, busy, done}, 32'b100);
        doneLeak = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0) doneLeak = 1'b1;
        end
        checkOutput("abort no_done", {31'd0, doneLeak}, 0);
        rst_n = 1'b1;
        applyStimulus(4'd3);
        waitForDone("after_reset", 15'h0007, 4, 3);

        // start held through FILL/DONE with a new count: only IDLE may accept it
        @(negedge clk);
        start = 1'b1;
        count = 4'd5;
        @(posedge clk);
        #1;
        count = 4'd12;
        waitForDone("held_first", 15'h001F, 6, 5);
        @(posedge clk);
        #1;
        start = 1'b0;
        waitForDone("held_second", 15'h0FFF, 13, 12);

`ifdef OC_UNARY_LOOPBACK_CHECK_EN
        applyStimulus(4'd4);
        repeat (2) @(negedge clk);
        force dut.y_q = 15'h0FFF;
        begin
            int guard = 0;
            while (done !== 1'b1 && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            checkOutput("force reached_done", {31'd0, done}, 1);
        end
        @(negedge clk);
        release dut.y_q;
        checkOutput("force err_set", {31'd0, err}, 1);
        @(negedge clk);
        checkOutput("force err_sticky", {31'd0, err}, 1);
        applyStimulus(4'd2);
        checkOutput("force err_cleared", {31'd0, err}, 0);
        repeat (4) @(negedge clk);
        checkOutput("recheck err", {31'd0, err}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

endmodule : tb_oc_unary_expander
